// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives one scan chain per test.
// Sequence: load a parallel pattern serially (MSB first), pulse one functional
// capture cycle, unload the response, then compare it against a masked
// expected vector.
//
// Optional feature macro: SCAN_CHAIN_CTRL_ERRCNT_EN
//   Adds err_cnt, the saturating count of masked mismatching bits, and
//   fail_sticky, the OR of fail since reset.
//
// Ports:
//   CP           clock, rising edge
//   CD           asynchronous active-low reset
//   start        test request, sampled when idle or in the done cycle
//   pat          pattern to load; bit k ends in chain flop k
//   exp          expected response
//   mask         compare enable per bit (1 = compare)
//   so           scan-out from the last chain flop
//   te           scan enable to the chain
//   ti           serial data into chain flop 0
//   busy         test in progress
//   done         one-cycle result-valid pulse
//   fail         masked mismatch of the last test
//   resp         captured response of the last test
//   err_cnt      (macro only) masked mismatching bit count, saturating at 255
//   fail_sticky  (macro only) OR of fail since reset
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                 CP,
  input  logic                 CD,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat,
  input  logic [CHAIN_LEN-1:0] exp,
  input  logic [CHAIN_LEN-1:0] mask,
  input  logic                 so,
  output logic                 te,
  output logic                 ti,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
  output logic [7:0]           err_cnt,
  output logic                 fail_sticky,
`endif
  output logic [CHAIN_LEN-1:0] resp
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CAPT   = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_sh_q, pat_sh_d;
  logic [CHAIN_LEN-1:0] exp_sh_q, exp_sh_d;
  logic [CHAIN_LEN-1:0] mask_sh_q, mask_sh_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 te_q, te_d;
  logic                 ti_q, ti_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;

  // Response including the current so sample, and its masked mismatch bits.
  logic [CHAIN_LEN-1:0] resp_c;
  logic [CHAIN_LEN-1:0] miss_c;

`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       sticky_q, sticky_d;
  logic [7:0] miss_cnt_c;

  // Saturating popcount of the masked mismatch vector.
  always_comb begin
    miss_cnt_c = 8'd0;
    for (int k = 0; k < int'(CHAIN_LEN); k++) begin
      if (miss_c[k] && (miss_cnt_c != 8'hFF)) begin
        miss_cnt_c = miss_cnt_c + 8'd1;
      end
    end
  end
`endif

  // State and datapath registers.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pat_sh_q  <= '0;
      exp_sh_q  <= '0;
      mask_sh_q <= '0;
      cap_q     <= '0;
      resp_q    <= '0;
      te_q      <= 1'b0;
      ti_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
      err_cnt_q <= 8'd0;
      sticky_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pat_sh_q  <= pat_sh_d;
      exp_sh_q  <= exp_sh_d;
      mask_sh_q <= mask_sh_d;
      cap_q     <= cap_d;
      resp_q    <= resp_d;
      te_q      <= te_d;
      ti_q      <= ti_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
`endif
    end
  end

  // Next-state and registered-output logic. te/ti are computed for the
  // state being entered, so the chain sees them in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pat_sh_d  = pat_sh_q;
    exp_sh_d  = exp_sh_q;
    mask_sh_d = mask_sh_q;
    cap_d     = cap_q;
    resp_d    = resp_q;
    te_d      = 1'b0;
    ti_d      = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fail_d    = fail_q;
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
`endif

    // Older samples move up; the first sample ends in bit CHAIN_LEN-1.
    resp_c = CHAIN_LEN'({cap_q, so});
    miss_c = (resp_c ^ exp_sh_q) & mask_sh_q;

    case (state_q)
      // The done cycle also accepts start so that tests can run back to back.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          pat_sh_d  = pat;
          exp_sh_d  = exp;
          mask_sh_d = mask;
          busy_d    = 1'b1;
          te_d      = 1'b1;
          ti_d      = pat[CHAIN_LEN-1];
        end
      end

      S_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          te_d  = 1'b1;
          // Present pattern bit CHAIN_LEN-1-cnt_d for the next shift.
          for (int k = 0; k < int'(CHAIN_LEN); k++) begin
            if ((32'(k) + 32'(cnt_q) + 32'd1) == 32'(CHAIN_LEN - 1)) begin
              ti_d = pat_sh_q[k];
            end
          end
        end
      end

      S_CAPT: begin
        state_d = S_UNLOAD;
        cnt_d   = '0;
        te_d    = 1'b1;
      end

      S_UNLOAD: begin
        cap_d = resp_c;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          resp_d  = resp_c;
          fail_d  = |miss_c;
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
          err_cnt_d = miss_cnt_c;
          sticky_d  = sticky_q | (|miss_c);
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          te_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign te   = te_q;
  assign ti   = ti_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;
  assign resp = resp_q;
`ifdef SCAN_CHAIN_CTRL_ERRCNT_EN
  assign err_cnt     = err_cnt_q;
  assign fail_sticky = sticky_q;
`endif

endmodule
